inst_fetch: RTL



---
 rtl/inst_fetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: assembles 32-bit little-endian words from a byte-wide read port.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_interception,
  input  logic [31:0] branch_target,
  input  logic        ifid_stall,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [1:0]  r_issue_cnt;
  logic [1:0]  r_cap_cnt;
  logic        r_pending;
  logic [23:0] r_bytes;

  logic        w_issue;
  logic [31:0] w_word;
  logic        w_fill;
  logic        w_unused;

  // Handshake: a byte is issued on any cycle with mem_req && mem_grant; its data
  // is on mem_din exactly one cycle later and is captured only via r_pending.
  assign w_issue  = r_mem_req && mem_grant;
  assign w_word   = {mem_din, r_bytes};
  assign w_fill   = (r_state == S_FETCH) && r_pending && (r_cap_cnt == 2'd3)
                    && !rst && !branch_interception;
  assign w_unused = ^{ICACHE_LINES, branch_target[1:0], w_fill};

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]       r_cache_data  [ICACHE_LINES];
  logic [TAG_W-1:0]  r_cache_tag   [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] r_cache_valid;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;

  assign w_idx = r_pc[IDX_W+1:2];
  assign w_tag = r_pc[31:IDX_W+2];
  assign w_hit = r_cache_valid[w_idx] && (r_cache_tag[w_idx] == w_tag);

  // Storage carries no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_cache_data[w_idx] <= w_word;
      r_cache_tag[w_idx]  <= w_tag;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_if_pc     <= 32'h0;
      r_if_inst   <= 32'h0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_issue_cnt <= 2'd0;
      r_cap_cnt   <= 2'd0;
      r_pending   <= 1'b0;
      r_bytes     <= 24'h0;
`ifdef ICACHE_EN
      r_cache_valid <= '0;
`endif
    end else if (branch_interception) begin
      r_state     <= S_IDLE;
      r_pc        <= {branch_target[31:2], 2'b00};
      r_if_pc     <= 32'h0;
      r_if_inst   <= 32'h0;
      r_mem_req   <= 1'b0;
      r_issue_cnt <= 2'd0;
      r_cap_cnt   <= 2'd0;
      r_pending   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef ICACHE_EN
          if (w_hit) begin
            r_if_pc   <= r_pc;
            r_if_inst <= r_cache_data[w_idx];
            r_state   <= S_PRESENT;
          end else
`endif
          begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= r_pc;
            r_issue_cnt <= 2'd0;
            r_cap_cnt   <= 2'd0;
            r_pending   <= 1'b0;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_pending <= w_issue;
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 2'd1;
            if (r_issue_cnt == 2'd3) r_mem_req  <= 1'b0;
            else                     r_mem_addr <= r_mem_addr + 32'd1;
          end
          if (r_pending) begin
            r_cap_cnt <= r_cap_cnt + 2'd1;
            case (r_cap_cnt)
              2'd0:    r_bytes[7:0]   <= mem_din;
              2'd1:    r_bytes[15:8]  <= mem_din;
              2'd2:    r_bytes[23:16] <= mem_din;
              default: begin
                r_if_pc   <= r_pc;
                r_if_inst <= w_word;
                r_state   <= S_PRESENT;
`ifdef ICACHE_EN
                r_cache_valid[w_idx] <= 1'b1;
`endif
              end
            endcase
          end
        end
        S_PRESENT: begin
          if (!ifid_stall) begin
            r_pc      <= r_pc + 32'd4;
            r_if_inst <= 32'h0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign dbg_state = r_state;

endmodule
